// File: rtl/req_capture_rr_if.sv
// rtl/req_capture_rr_if.sv - grant offer handshake between req_capture_rr and its consumer
interface req_capture_rr_if #(
    parameter int N = 3
);
    logic                 out_valid;
    logic                 out_ready;
    logic [(1<<N)-1:0]    grant_onehot;
    logic [N-1:0]         grant_idx;

    modport master (
        output out_valid,
        output grant_onehot,
        output grant_idx,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  grant_onehot,
        input  grant_idx,
        output out_ready
    );
endinterface

// File: rtl/req_capture_rr.sv
// rtl/req_capture_rr.sv - latch request pulses and offer one pending source per round-robin
module req_capture_rr #(
    parameter int N = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [(1<<N)-1:0]    req_in,
    req_capture_rr_if.master     grant,
    output logic [(1<<N)-1:0]    pending,
    output logic                 overflow
);
    localparam int W = 1 << N;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    state_t         state_q, state_n;
    logic [N-1:0]   ptr_q, ptr_n;
    logic [W-1:0]   pending_q, pending_n;
    logic           overflow_q, overflow_n;
    logic           valid_q, valid_n;
    logic [W-1:0]   onehot_q, onehot_n;
    logic [N-1:0]   idx_q, idx_n;

    logic [W-1:0]   clr;
    logic           accept;
    logic           found;
    logic [N-1:0]   sel;
    logic [N-1:0]   cand;

    // First pending bit at or after ptr, wrapping through the N-bit index space.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int k = 0; k < W; k++) begin
            cand = ptr_q + N'(k);
            if (!found && pending_q[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    always_comb begin
        state_n  = state_q;
        ptr_n    = ptr_q;
        valid_n  = valid_q;
        onehot_n = onehot_q;
        idx_n    = idx_q;
        clr      = '0;
        accept   = 1'b0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    onehot_n      = '0;
                    onehot_n[sel] = 1'b1;
                    idx_n         = sel;
                    valid_n       = 1'b1;
                    state_n       = OFFER;
                end
            end
            OFFER: begin
                accept = grant.out_ready;
                if (accept) begin
                    clr      = onehot_q;
                    ptr_n    = idx_q + N'(1);
                    valid_n  = 1'b0;
                    onehot_n = '0;
                    idx_n    = '0;
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        // A request landing on the bit being cleared is a fresh request, not a duplicate.
        pending_n  = (pending_q & ~clr) | req_in;
        overflow_n = |(req_in & pending_q & ~clr);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
            onehot_q   <= '0;
            idx_q      <= '0;
        end else begin
            state_q    <= state_n;
            ptr_q      <= ptr_n;
            pending_q  <= pending_n;
            overflow_q <= overflow_n;
            valid_q    <= valid_n;
            onehot_q   <= onehot_n;
            idx_q      <= idx_n;
        end
    end

    assign grant.out_valid    = valid_q;
    assign grant.grant_onehot = onehot_q;
    assign grant.grant_idx    = idx_q;
    assign pending            = pending_q;
    assign overflow           = overflow_q;
endmodule

// File: tb/tb_req_capture_rr.sv
// tb/tb_req_capture_rr.sv - directed checks of req_capture_rr capture, round-robin and handshake
module tb_req_capture_rr;
    localparam int N = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req_in;
    logic [7:0] pending;
    logic       overflow;

    int n_checks = 0;
    int n_errors = 0;

    req_capture_rr_if #(.N(N)) gif ();

    req_capture_rr #(.N(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_in   (req_in),
        .grant    (gif.master),
        .pending  (pending),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle, then check the grant shape invariant away from the edge.
    task automatic tick();
        logic [7:0] exp_oh;
        @(posedge clk);
        #1;
        exp_oh = gif.out_valid ? (8'h01 << gif.grant_idx) : 8'h00;
        check("inv_onehot", {24'd0, gif.grant_onehot}, {24'd0, exp_oh});
    endtask

    task automatic expect_offer(input string tag, input int idx);
        check({tag, "_valid"}, {31'd0, gif.out_valid}, 32'd1);
        check({tag, "_idx"}, {29'd0, gif.grant_idx}, idx);
    endtask

    task automatic expect_idle(input string tag, input logic [7:0] pend);
        check({tag, "_valid"}, {31'd0, gif.out_valid}, 32'd0);
        check({tag, "_pend"}, {24'd0, pending}, {24'd0, pend});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_in = 8'h00;
        gif.out_ready = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        // 1: reset with all requests asserted
        rst_n = 1'b0;
        req_in = 8'hFF;
        gif.out_ready = 1'b0;
        tick();
        tick();
        check("rst_pend", {24'd0, pending}, 32'h0);
        check("rst_valid", {31'd0, gif.out_valid}, 32'd0);
        check("rst_oh", {24'd0, gif.grant_onehot}, 32'h0);
        check("rst_idx", {29'd0, gif.grant_idx}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        rst_n = 1'b1;
        req_in = 8'h00;
        tick();
        tick();
        expect_idle("post_rst", 8'h00);
        check("post_rst_ovf", {31'd0, overflow}, 32'd0);

        // 2: single pulse latency
        req_in = 8'h20;
        gif.out_ready = 1'b1;
        tick();
        req_in = 8'h00;
        expect_idle("t2_cap", 8'h20);
        tick();
        expect_offer("t2_offer", 5);
        check("t2_oh", {24'd0, gif.grant_onehot}, 32'h20);
        tick();
        expect_idle("t2_done", 8'h00);

        // 3: wrap from 7 back to 0, twice
        do_reset();
        for (int r = 0; r < 2; r++) begin
            req_in = 8'h81;
            gif.out_ready = 1'b1;
            tick();
            req_in = 8'h00;
            expect_idle("t3_cap", 8'h81);
            tick();
            expect_offer("t3_g0", 0);
            tick();
            expect_idle("t3_a0", 8'h80);
            tick();
            expect_offer("t3_g7", 7);
            tick();
            expect_idle("t3_a7", 8'h00);
        end

        // 4: held offer while new request arrives, then drain 3,4,0
        gif.out_ready = 1'b0;
        req_in = 8'h1C;
        tick();
        req_in = 8'h00;
        tick();
        expect_offer("t4_hold0", 2);
        for (int c = 0; c < 5; c++) begin
            req_in = (c == 2) ? 8'h01 : 8'h00;
            tick();
            expect_offer("t4_hold", 2);
        end
        req_in = 8'h00;
        check("t4_pend", {24'd0, pending}, 32'h1D);
        gif.out_ready = 1'b1;
        tick();
        expect_idle("t4_a2", 8'h19);
        tick();
        expect_offer("t4_g3", 3);
        tick();
        tick();
        expect_offer("t4_g4", 4);
        tick();
        expect_idle("t4_a4", 8'h01);
        tick();
        expect_offer("t4_g0", 0);
        tick();
        expect_idle("t4_a0", 8'h00);

        // 5: duplicate request overflow, and same-cycle re-request on accept
        do_reset();
        req_in = 8'h08;
        gif.out_ready = 1'b1;
        tick();
        req_in = 8'h00;
        tick();
        expect_offer("t5_g3", 3);
        tick();
        gif.out_ready = 1'b0;
        req_in = 8'h14;
        tick();
        req_in = 8'h00;
        tick();
        expect_offer("t5_g4", 4);
        req_in = 8'h04;
        tick();
        req_in = 8'h00;
        check("t5_ovf1", {31'd0, overflow}, 32'd1);
        check("t5_pend1", {24'd0, pending}, 32'h14);
        tick();
        check("t5_ovf0", {31'd0, overflow}, 32'd0);
        req_in = 8'h10;
        gif.out_ready = 1'b1;
        tick();
        req_in = 8'h00;
        gif.out_ready = 1'b0;
        expect_idle("t5_acc", 8'h14);
        check("t5_acc_ovf", {31'd0, overflow}, 32'd0);
        tick();
        expect_offer("t5_ptr5", 2);

        // 6: reset drops an in-flight offer
        do_reset();
        req_in = 8'h40;
        tick();
        req_in = 8'h00;
        tick();
        expect_offer("t6_g6", 6);
        tick();
        expect_offer("t6_hold", 6);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        expect_idle("t6_rst", 8'h00);
        req_in = 8'h41;
        tick();
        req_in = 8'h00;
        tick();
        expect_offer("t6_ptr0", 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
